encoder_66b_64b_tx: RTL and testbench
=====================================

ENCODER_66B_64B_TX -- requirements
Module: encoder_66b_64b

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, payload width; only 64 supported.
REQ-002 SHALL have parameter HEADER_WIDTH, default 2, sync-header width; only 2 supported.
REQ-003 SHALL have parameter REVERSE, default 0, 1 = bit-reverse the 64 payload bits of encoded_data.
REQ-004 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  qualifies data_bits/control_bits this cycle.
REQ-007 SHALL have port data_bits  input  64  XGMII TXD; byte lane i = bits [8i+7:8i], lane 0 first.
REQ-008 SHALL have port control_bits  input  8  XGMII TXC; bit i = 1 marks lane i as control.
REQ-009 SHALL have port encoded_data  output  66  [1:0] sync header, [65:2] payload, bit 0 transmitted first.
REQ-010 SHALL have port enable_scrambler  output  1  high when encoded_data holds a valid block.
REQ-011 SHALL have port scrambled_data  output  66  scrambled block, present only with ENC_SCRAMBLER_EN.

Function
REQ-012 Latency SHALL be 1 cycle: inputs sampled at edge N appear on encoded_data after edge N.
REQ-013 enable_scrambler SHALL equal enable registered one cycle.
REQ-014 With enable low, encoded_data SHALL hold its previous value.
REQ-015 control_bits = 8'h00 SHALL give a data block: encoded_data[0]=0, [1]=1, payload = data_bits.
REQ-016 Any other control_bits SHALL give a control block: encoded_data[0]=1, [1]=0; block type byte in encoded_data[9:2].
REQ-017 Control mapping, XGMII to 7-bit: /I/ 8'h07 -> 7'h00, /E/ 8'hFE -> 7'h1E; /S/ 8'hFB, /T/ 8'hFD, /O/ 8'h9C are positional only.
REQ-018 Supported types, field layout per IEEE 802.3 clause 49, fields packed LSB-first after the type byte:
  - 0x1E: all 8 lanes /I/ or /E/.
  - 0x78: /S/ in lane 0, lanes 1-7 data.
  - 0x4B: /O/ in lane 0, lanes 1-3 data, lanes 4-7 /I/.
  - T blocks: /T/ in lane k, lanes <k data, lanes >k /I/ or /E/; k=0..7 gives type 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF.
REQ-019 Any unsupported or malformed pattern SHALL give an error block: control header, type 0x1E, all eight codes 7'h1E.
REQ-020 With REVERSE=1, payload bits [65:2] SHALL be bit-reversed after encoding; the header SHALL NOT be reversed.

Reset
REQ-021 With RST high at a rising edge, encoded_data SHALL be 0 and enable_scrambler SHALL be 0.
REQ-022 RST SHALL override enable.
REQ-023 Scrambler state SHALL reset to all ones (58'h3FF_FFFF_FFFF_FFFF) and scrambled_data SHALL reset to 0.
REQ-024 The first valid block SHALL be the one sampled at the first edge with RST low and enable high.

Configuration
REQ-025 With macro ENC_SCRAMBLER_EN defined, a self-synchronous scrambler x^58+x^39+1 SHALL be compiled in:
  - scrambles payload bits 2..65 in transmit order; header passes unscrambled.
  - adds one further register stage: 2 cycles from input to scrambled_data.
  - state advances only when enable_scrambler is high.
REQ-026 Without ENC_SCRAMBLER_EN, the scrambled_data port and all scrambler logic SHALL be absent.

Structure
REQ-027 A shared package SHALL hold:
  - sync-header constants (2'b10 data, 2'b01 control, as [1:0] values).
  - block-type constants.
  - XGMII control-character constants.
  - 7-bit control-code constants.
  - scrambler polynomial taps and seed.
REQ-028 The scrambler SHALL be one sub-module, scrambler_64b, instantiated under ENC_SCRAMBLER_EN.

Verification
REQ-029 Idle: control 8'hFF, data 64'h0707070707070707, enable 1 -> one cycle later encoded_data[1:0]=2'b01, [9:2]=8'h1E, [65:10]=0.
REQ-030 Data: control 8'h00, data 64'h0123456789ABCDEF -> encoded_data = {64'h0123456789ABCDEF, 2'b10}, enable_scrambler=1.
REQ-031 Start: control 8'h01, data 64'h555555555555_55FB -> header 2'b01, type 8'h78, payload[63:8] = 56'h55555555555555.
REQ-032 Terminate: control 8'hFE, lane 0 8'hAA, lane 1 8'hFD, lanes 2-7 8'h07 -> type 8'h99, D0=8'hAA, remaining bits 0.
REQ-033 Error and reset: control 8'h01 with lane 0 8'h00 -> error block (REQ-019); RST asserted mid-stream -> encoded_data=0 and enable_scrambler=0 on the next edge.
REQ-034 Scrambler, ENC_SCRAMBLER_EN defined: stream of 4 data blocks -> header unchanged, payload matches a bit-serial x^58+x^39+1 model seeded all ones, 2-cycle latency.

Source files
------------

// File: rtl/encoder_66b_64b_tx_pkg.sv
// encoder_66b_64b_tx_pkg: shared constants and the clause-49 block encoding function
package encoder_66b_64b_tx_pkg;

    localparam logic [1:0] SH_DATA = 2'b10;
    localparam logic [1:0] SH_CTRL = 2'b01;

    localparam logic [7:0] BT_IDLE = 8'h1E;
    localparam logic [7:0] BT_S0   = 8'h78;
    localparam logic [7:0] BT_O0   = 8'h4B;
    // Terminate block types, lane k of /T/ selects byte k
    localparam logic [63:0] BT_T   = 64'hFF_E1_D2_CC_B4_AA_99_87;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;

    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    // x^39 and x^58 taps on a history where bit 0 is the most recent output
    localparam int          SCR_TAP_A = 38;
    localparam int          SCR_TAP_B = 57;
    localparam logic [57:0] SCR_SEED  = 58'h3FF_FFFF_FFFF_FFFF;

    function automatic logic is_ie(input logic [7:0] x);
        return x == XGMII_IDLE || x == XGMII_ERROR;
    endfunction

    function automatic logic [6:0] code7(input logic [7:0] x);
        return (x == XGMII_ERROR) ? CODE_ERROR : CODE_IDLE;
    endfunction

    function automatic logic [63:0] bit_reverse64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    function automatic logic [65:0] encode_block(input logic [63:0] d, input logic [7:0] c);
        logic [7:0]  lane [8];
        logic [63:0] p;
        logic        all_ie;
        logic        tail_ok;
        all_ie = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lane[i] = d[8*i +: 8];
            all_ie  = all_ie & is_ie(lane[i]);
        end
        if (c == 8'h00) return {d, SH_DATA};
        p = {{8{CODE_ERROR}}, BT_IDLE};
        if (c == 8'hFF && all_ie) begin
            p[7:0] = BT_IDLE;
            for (int j = 0; j < 8; j++) p[8+7*j +: 7] = code7(lane[j]);
        end else if (c == 8'h01 && lane[0] == XGMII_START) begin
            p = {d[63:8], BT_S0};
        end else if (c == 8'hF1 && lane[0] == XGMII_SEQ && d[63:32] == {4{XGMII_IDLE}}) begin
            p = {28'h0, 4'h0, d[31:8], BT_O0};
        end else begin
            for (int k = 0; k < 8; k++) begin
                tail_ok = 1'b1;
                for (int j = 0; j < 8; j++) if (j > k && !is_ie(lane[j])) tail_ok = 1'b0;
                if (c == (8'hFF << k) && lane[k] == XGMII_TERM && tail_ok) begin
                    p = '0;
                    p[7:0] = BT_T[8*k +: 8];
                    for (int j = 0; j < 7; j++) if (j < k) p[8+8*j +: 8] = lane[j];
                    // trailing control codes sit at the top, padding fills the gap
                    for (int j = 1; j < 8; j++) if (j > k) p[64-7*(8-j) +: 7] = code7(lane[j]);
                end
            end
        end
        return {p, SH_CTRL};
    endfunction

endpackage

// File: rtl/encoder_66b_64b_tx_scrambler_64b.sv
// scrambler_64b: self-synchronous x^58+x^39+1 payload scrambler with one register stage
module scrambler_64b
    import encoder_66b_64b_tx_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_valid,
    input  logic [65:0] i_block,
    output logic [65:0] o_block
);

    logic [57:0] r_state;
    logic [57:0] w_state;
    logic [63:0] w_payload;

    always_comb begin
        w_state   = r_state;
        w_payload = '0;
        for (int i = 0; i < 64; i++) begin
            w_payload[i] = i_block[i+2] ^ w_state[SCR_TAP_A] ^ w_state[SCR_TAP_B];
            w_state      = {w_state[56:0], w_payload[i]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= SCR_SEED;
            o_block <= '0;
        end else if (i_valid) begin
            r_state <= w_state;
            o_block <= {w_payload, i_block[1:0]};
        end
    end

endmodule

// File: rtl/encoder_66b_64b_tx.sv
// encoder_66b_64b_tx: XGMII to 64b/66b block encoder, optional scrambler under ENC_SCRAMBLER_EN
module encoder_66b_64b_tx
    import encoder_66b_64b_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int HEADER_WIDTH = 2,
    parameter int REVERSE      = 0
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               enable,
    input  logic [DATA_WIDTH-1:0]              data_bits,
    input  logic [7:0]                         control_bits,
    output logic [DATA_WIDTH+HEADER_WIDTH-1:0] encoded_data,
    output logic                               enable_scrambler
`ifdef ENC_SCRAMBLER_EN
    ,
    output logic [DATA_WIDTH+HEADER_WIDTH-1:0] scrambled_data
`endif
);

    logic [65:0] w_enc;
    logic [65:0] w_block;

    assign w_enc   = encode_block(data_bits, control_bits);
    assign w_block = (REVERSE != 0) ? {bit_reverse64(w_enc[65:2]), w_enc[1:0]} : w_enc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            encoded_data     <= '0;
            enable_scrambler <= 1'b0;
        end else begin
            enable_scrambler <= enable;
            if (enable) encoded_data <= w_block;
        end
    end

`ifdef ENC_SCRAMBLER_EN
    scrambler_64b u_scrambler (
        .CLK     (CLK),
        .RST     (RST),
        .i_valid (enable_scrambler),
        .i_block (encoded_data),
        .o_block (scrambled_data)
    );
`endif

endmodule

// File: tb/tb_encoder_66b_64b_tx.sv
// tb_encoder_66b_64b_tx: directed vectors against hand-computed 66-bit blocks
module tb_encoder_66b_64b_tx;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] data_bits = '0;
    logic [7:0]  control_bits = '0;
    logic [65:0] encoded_data, encoded_rev;
    logic        enable_scrambler, enable_rev;
    int          n_checks = 0;
    int          n_errors = 0;

    localparam logic [63:0] ERR_P = {{8{7'h1E}}, 8'h1E};

    always #5 CLK = ~CLK;

`ifdef ENC_SCRAMBLER_EN
    logic [65:0] scrambled_data, scrambled_rev;
    logic [57:0] m_state;
    logic [63:0] m_pay;
    logic [65:0] m_exp [4];
    logic [63:0] s_data [4] = '{64'h0123456789ABCDEF, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hA5A55A5A0F0FF0F0};
`endif

    encoder_66b_64b_tx u_dut (
        .CLK              (CLK),
        .RST              (RST),
        .enable           (enable),
        .data_bits        (data_bits),
        .control_bits     (control_bits),
        .encoded_data     (encoded_data),
        .enable_scrambler (enable_scrambler)
`ifdef ENC_SCRAMBLER_EN
        ,
        .scrambled_data   (scrambled_data)
`endif
    );

    encoder_66b_64b_tx #(.REVERSE(1)) u_rev (
        .CLK              (CLK),
        .RST              (RST),
        .enable           (enable),
        .data_bits        (data_bits),
        .control_bits     (control_bits),
        .encoded_data     (encoded_rev),
        .enable_scrambler (enable_rev)
`ifdef ENC_SCRAMBLER_EN
        ,
        .scrambled_data   (scrambled_rev)
`endif
    );

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst_v, input logic en_v, input logic [7:0] c, input logic [63:0] d);
        @(negedge CLK);
        RST = rst_v;
        enable = en_v;
        control_bits = c;
        data_bits = d;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [65:0] rev66(input logic [65:0] x);
        logic [63:0] p;
        p = {<<{x[65:2]}};
        return {p, x[1:0]};
    endfunction

    task automatic vec(input string tag, input logic [7:0] c, input logic [63:0] d, input logic [65:0] exp);
        step(1'b0, 1'b1, c, d);
        check(tag, encoded_data, exp);
        check({tag, "_rev"}, encoded_rev, rev66(exp));
        check({tag, "_en"}, {65'h0, enable_scrambler}, 66'h1);
    endtask

    initial begin
        step(1'b1, 1'b1, 8'h00, 64'hDEADBEEFDEADBEEF);
        check("rst_enc", encoded_data, 66'h0);
        check("rst_en", {65'h0, enable_scrambler}, 66'h0);
`ifdef ENC_SCRAMBLER_EN
        check("rst_scr", scrambled_data, 66'h0);
`endif
        step(1'b0, 1'b0, 8'h00, 64'h1111111111111111);
        check("first_wait_enc", encoded_data, 66'h0);
        check("first_wait_en", {65'h0, enable_scrambler}, 66'h0);

        vec("idle", 8'hFF, 64'h0707070707070707, 66'h79);
        vec("data", 8'h00, 64'h0123456789ABCDEF, {64'h0123456789ABCDEF, 2'b10});
        step(1'b0, 1'b0, 8'hFF, 64'h0707070707070707);
        check("hold_enc", encoded_data, {64'h0123456789ABCDEF, 2'b10});
        check("hold_en", {65'h0, enable_scrambler}, 66'h0);
        vec("start", 8'h01, 64'h55555555555555FB, {56'h55555555555555, 8'h78, 2'b01});
        vec("term1", 8'hFE, 64'h070707070707FDAA, {48'h0, 8'hAA, 8'h99, 2'b01});
        vec("err_start", 8'h01, 64'h5555555555555500, {ERR_P, 2'b01});
        vec("idle_mix", 8'hFF, 64'hFE07FE07FE07FE07,
            {7'h1E, 7'h00, 7'h1E, 7'h00, 7'h1E, 7'h00, 7'h1E, 7'h00, 8'h1E, 2'b01});
        vec("term0", 8'hFF, 64'h07070707070707FD, {56'h0, 8'h87, 2'b01});
        vec("term7", 8'h80, 64'hFD77665544332211, {56'h77665544332211, 8'hFF, 2'b01});
        vec("term3", 8'hF8, 64'hFE0707FEFDC3B2A1,
            {7'h1E, 7'h00, 7'h00, 7'h1E, 4'h0, 24'hC3B2A1, 8'hB4, 2'b01});
        vec("ordered", 8'hF1, 64'h070707073322119C, {32'h0, 24'h332211, 8'h4B, 2'b01});
        vec("err_term", 8'hFE, 64'h070707070700FDAA, {ERR_P, 2'b01});
        vec("err_ctl", 8'h10, 64'h0000000707000000, {ERR_P, 2'b01});

        step(1'b1, 1'b1, 8'h00, 64'hCAFEF00DCAFEF00D);
        check("midrst_enc", encoded_data, 66'h0);
        check("midrst_en", {65'h0, enable_scrambler}, 66'h0);
        vec("after_rst", 8'h00, 64'h1122334455667788, {64'h1122334455667788, 2'b10});

`ifdef ENC_SCRAMBLER_EN
        step(1'b1, 1'b0, 8'h00, 64'h0);
        m_state = 58'h3FF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 64; b++) begin
                m_pay[b] = s_data[i][b] ^ m_state[38] ^ m_state[57];
                m_state = {m_state[56:0], m_pay[b]};
            end
            m_exp[i] = {m_pay, 2'b10};
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h00, s_data[i]);
            if (i == 0) check("scr_lat", scrambled_data, 66'h0);
            else check($sformatf("scr%0d", i - 1), scrambled_data, m_exp[i-1]);
        end
        step(1'b0, 1'b0, 8'h00, 64'h0);
        check("scr3", scrambled_data, m_exp[3]);
        step(1'b0, 1'b0, 8'h00, 64'h0);
        check("scr_hold", scrambled_data, m_exp[3]);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
